memwrite_checker: RTL and testbench
===================================

Name: memwrite_checker

Overview:
- Synthesizable, parametrised self-check monitor for processor data-memory write traffic. It replaces the fixed single-address pass/fail check in the top-level simulation bench.
- Sits beside the top level and snoops memwrite/dataadr/writedata.
- Matches writes in order against a programmable expected-write table and tolerates writes into a programmable ignore window.
- Flags PASS, FAIL (unexpected write) or FAIL (timeout), and reports match, ignore and cycle counts.

Parameters:
- AW, 32, address width.
- DW, 32, write-data width.
- DEPTH, 8, expected-table entries (power of 2, >=2).
- TIMEOUT, 1000, RUN cycles before a timeout FAIL.
- CW, 16, width of the ignore and cycle counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; arms the checker from IDLE, PASS or FAIL.
- num_exp  in  clog2(DEPTH)+1  number of valid table entries, 0..DEPTH; sampled at start.
- tbl_we  in  1  table write strobe; honoured only when state is not RUN.
- tbl_idx  in  clog2(DEPTH)  table entry index.
- tbl_addr  in  AW  expected address.
- tbl_data  in  DW  expected data.
- ign_base  in  AW  ignore-window base.
- ign_mask  in  AW  ignore-window compare mask.
- memwrite  in  1  snooped write strobe.
- dataadr  in  AW  snooped address.
- writedata  in  DW  snooped data.
- busy  out  1  state==RUN.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state==PASS.
- fail  out  1  state==FAIL.
- fail_code  out  2  0 none, 1 unexpected write, 2 timeout.
- match_cnt  out  clog2(DEPTH)+1  expected writes matched.
- ign_cnt  out  CW  tolerated writes; saturates at all-ones.
- cycles  out  CW  RUN cycles elapsed; saturates.
- fail_addr  out  AW  see Optional Feature.
- fail_data  out  DW  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0 and all table entries are 0.
  - Reset wins over every other input in the same cycle, including mid-RUN.
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL + start:
  - Enter RUN next cycle; match_cnt, ign_cnt, cycles and fail_code are cleared.
  - num_exp is latched. The table is retained.
  - If num_exp==0, enter PASS one cycle after RUN is entered.
- A tbl_we in the same cycle as start is applied, and the new entry is used by this run. A tbl_we during RUN is ignored.
- RUN, each cycle:
  - cycles increments (saturating).
  - If memwrite=1, evaluate in this priority order:
    - (a) dataadr==tbl_addr[match_cnt] and writedata==tbl_data[match_cnt]: match_cnt increments. If the new match_cnt equals the latched num_exp, go to PASS.
    - (b) (dataadr & ign_mask)==(ign_base & ign_mask): ign_cnt increments.
    - (c) otherwise: go to FAIL with fail_code=1.
  - memwrite=0: no check.
  - Writedata is compared even for ignored addresses? No — an ignored-window write is tolerated regardless of data.
- Timeout:
  - When cycles reaches TIMEOUT-1 and no PASS/FAIL transition occurs that cycle, go to FAIL with fail_code=2.
  - A final match in the same cycle as the timeout yields PASS.
  - An unexpected write in the same cycle as the timeout yields fail_code=1.
- PASS and FAIL are sticky until reset or start. Counters freeze there, and memwrite is ignored there.
- Out-of-order expected writes:
  - Entry k arriving while entry j<k is pending counts as unexpected (FAIL code 1) unless it falls in the ignore window.
- Latency: a decision is visible on pass/fail 1 cycle after the deciding memwrite edge. Outputs are registered.

Optional Feature:
- Macro: MWCHK_CAPTURE_EN.
- Defined:
  - On entry to FAIL with code 1, fail_addr/fail_data latch the offending dataadr/writedata.
  - On timeout, fail_addr is loaded with the pending tbl_addr[match_cnt] and fail_data with the pending tbl_data[match_cnt].
  - Both are cleared by reset and by start.
- Undefined: fail_addr and fail_data are constant 0, and no capture registers are instantiated.

Test Plan:
- Baseline, tbl[0]=(84,7), num_exp=1, ign_base=80, ign_mask=FFFFFFFF, start.
  - Writes (80,x), (80,y), (84,7) -> pass=1 one cycle later, ign_cnt=2, match_cnt=1, fail_code=0.
- Same setup, write (88,5) -> fail=1, fail_code=1.
  - With MWCHK_CAPTURE_EN: fail_addr=88, fail_data=5.
- Ordering: tbl[0]=(84,7), tbl[1]=(88,9), num_exp=2, no ignore (ign_mask=FFFFFFFF, ign_base=0).
  - Write (88,9) first -> FAIL code 1.
  - Rerun with start, writes (84,7) then (88,9) -> PASS, match_cnt=2.
- Timeout: TIMEOUT=20, no memwrite after start.
  - fail=1, fail_code=2 exactly 20 cycles after busy rises. cycles=19 frozen.
- Simultaneity: final matching write on the timeout cycle -> PASS. tbl_we with start -> new entry used.
- Reset mid-RUN after one match -> all outputs 0 next cycle, table cleared, IDLE. num_exp=0 start -> PASS after 2 cycles.

Source files
------------

// File: rtl/memwrite_checker_if.sv
// Snooped data-memory write bus.
//   memwrite  : write strobe
//   dataadr   : write address (AW bits)
//   writedata : write data (DW bits)
// master drives the bus (processor / bench); slave snoops it (checker).
interface memwrite_checker_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/memwrite_checker.sv
// In-order self-check monitor for processor data-memory writes.
// Snoops the write bus, matches writes against a programmable expected
// table, tolerates writes into an ignore window, and reports PASS,
// FAIL(unexpected write) or FAIL(timeout) plus match/ignore/cycle counts.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : arm pulse (honoured outside RUN), latches num_exp
//   num_exp             : number of valid table entries 0..DEPTH
//   tbl_we/idx/addr/data: table write port, ignored during RUN
//   ign_base/ign_mask   : ignore window (masked address compare)
//   bus                 : snooped write bus (slave modport)
//   busy/done/pass/fail : state decode
//   fail_code           : 0 none, 1 unexpected write, 2 timeout
//   match_cnt/ign_cnt/cycles : counters (ign_cnt/cycles saturate)
//   fail_addr/fail_data : capture of the failing write / pending entry
//
// Optional: define MWCHK_CAPTURE_EN to build the fail capture registers;
// otherwise fail_addr/fail_data are tied to 0.
module memwrite_checker #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 16,
  localparam int IW     = $clog2(DEPTH),
  localparam int NW     = IW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NW-1:0]        num_exp,
  input  logic                 tbl_we,
  input  logic [IW-1:0]        tbl_idx,
  input  logic [AW-1:0]        tbl_addr,
  input  logic [DW-1:0]        tbl_data,
  input  logic [AW-1:0]        ign_base,
  input  logic [AW-1:0]        ign_mask,
  memwrite_checker_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [NW-1:0]        match_cnt,
  output logic [CW-1:0]        ign_cnt,
  output logic [CW-1:0]        cycles,
  output logic [AW-1:0]        fail_addr,
  output logic [DW-1:0]        fail_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0][AW-1:0] t_addr;
  logic [DEPTH-1:0][DW-1:0] t_data;
  logic [NW-1:0]            num_q;

  logic          hit, ign_hit, bad, tmo, arm;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;

  assign arm      = start && (state != S_RUN);
  // match_cnt < num_q <= DEPTH while in RUN, so the low bits index the table
  assign cur_addr = t_addr[match_cnt[IW-1:0]];
  assign cur_data = t_data[match_cnt[IW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    ign_hit   = 1'b0;
    bad       = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE, S_PASS, S_FAIL: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (num_q == '0) begin
          state_nxt = S_PASS;
        end else begin
          if (bus.memwrite) begin
            if (bus.dataadr == cur_addr && bus.writedata == cur_data) begin
              hit = 1'b1;
              if (match_cnt + NW'(1) == num_q) state_nxt = S_PASS;
            end else if ((bus.dataadr & ign_mask) == (ign_base & ign_mask)) begin
              ign_hit = 1'b1;
            end else begin
              bad       = 1'b1;
              state_nxt = S_FAIL;
            end
          end
          // timeout only if this cycle made no other decision
          if (state_nxt == S_RUN && cycles == CW'(TIMEOUT - 1)) begin
            tmo       = 1'b1;
            state_nxt = S_FAIL;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_addr    <= '0;
      t_data    <= '0;
      num_q     <= '0;
      match_cnt <= '0;
      ign_cnt   <= '0;
      cycles    <= '0;
      fail_code <= 2'd0;
    end else begin
      if (tbl_we && state != S_RUN) begin
        t_addr[tbl_idx] <= tbl_addr;
        t_data[tbl_idx] <= tbl_data;
      end
      if (arm) begin
        num_q     <= num_exp;
        match_cnt <= '0;
        ign_cnt   <= '0;
        cycles    <= '0;
        fail_code <= 2'd0;
      end else if (state == S_RUN) begin
        if (hit) match_cnt <= match_cnt + NW'(1);
        if (ign_hit && ign_cnt != '1) ign_cnt <= ign_cnt + CW'(1);
        // the exit cycle is not counted, so a timeout freezes at TIMEOUT-1
        if (state_nxt == S_RUN && cycles != '1) cycles <= cycles + CW'(1);
        if (bad)      fail_code <= 2'd1;
        else if (tmo) fail_code <= 2'd2;
      end
    end
  end

`ifdef MWCHK_CAPTURE_EN
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;

  always_ff @(posedge clk) begin
    if (reset || arm) begin
      cap_addr <= '0;
      cap_data <= '0;
    end else if (bad) begin
      cap_addr <= bus.dataadr;
      cap_data <= bus.writedata;
    end else if (tmo) begin
      cap_addr <= cur_addr;
      cap_data <= cur_data;
    end
  end

  assign fail_addr = cap_addr;
  assign fail_data = cap_data;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

  assign busy = (state == S_RUN);
  assign pass = (state == S_PASS);
  assign fail = (state == S_FAIL);
  assign done = pass | fail;

endmodule

// File: tb/tb_memwrite_checker.sv
// Self-checking bench for memwrite_checker: directed cases plus
// randomized runs scored against a write-list outcome predictor.
module tb_memwrite_checker;
  localparam int AW = 32, DW = 32, DEPTH = 8, TIMEOUT = 20, CW = 16;
  localparam int IW = $clog2(DEPTH), NW = IW + 1;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, tbl_we = 1'b0;
  logic [NW-1:0] num_exp = '0;
  logic [IW-1:0] tbl_idx = '0;
  logic [AW-1:0] tbl_addr = '0, ign_base = '0, ign_mask = '0;
  logic [DW-1:0] tbl_data = '0;
  logic busy, done, pass, fail;
  logic [1:0] fail_code;
  logic [NW-1:0] match_cnt;
  logic [CW-1:0] ign_cnt, cycles;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  memwrite_checker_if #(.AW(AW), .DW(DW)) bus ();

  memwrite_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .ign_base(ign_base), .ign_mask(ign_mask), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
    .match_cnt(match_cnt), .ign_cnt(ign_cnt), .cycles(cycles),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;

  // reference: table contents, latched count, per-cycle write schedule
  logic [AW-1:0] m_ta [DEPTH];
  logic [DW-1:0] m_td [DEPTH];
  int m_num;
  logic          sch_en [64];
  logic [AW-1:0] sch_a  [64];
  logic [DW-1:0] sch_d  [64];

  // predicted outcome of one run
  int e_t, e_match, e_ign, e_cyc, e_code;
  bit e_pass;
  logic [AW-1:0] e_fa;
  logic [DW-1:0] e_fd;
  int got_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_sch();
    for (int i = 0; i < 64; i++) begin
      sch_en[i] = 1'b0; sch_a[i] = '0; sch_d[i] = '0;
    end
  endtask

  task automatic put(input int t, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sch_en[t] = 1'b1; sch_a[t] = a; sch_d[t] = d;
  endtask

  task automatic wr_tbl(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    tbl_we = 1'b1; tbl_idx = IW'(idx); tbl_addr = a; tbl_data = d;
    tick();
    tbl_we = 1'b0;
    m_ta[idx] = a; m_td[idx] = d;
  endtask

  // Walk the write list cycle by cycle of RUN and decide the outcome.
  task automatic predict();
    e_match = 0; e_ign = 0; e_fa = '0; e_fd = '0; e_code = 0;
    if (m_num == 0) begin
      e_pass = 1; e_t = 0; e_cyc = 0; return;
    end
    for (int t = 0; t < TIMEOUT; t++) begin
      if (sch_en[t]) begin
        if (sch_a[t] == m_ta[e_match] && sch_d[t] == m_td[e_match]) begin
          e_match++;
          if (e_match == m_num) begin
            e_pass = 1; e_t = t; e_cyc = t; return;
          end
        end else if (((sch_a[t] ^ ign_base) & ign_mask) == '0) begin
          e_ign++;
        end else begin
          e_pass = 0; e_code = 1; e_fa = sch_a[t]; e_fd = sch_d[t];
          e_t = t; e_cyc = t; return;
        end
      end
    end
    e_pass = 0; e_code = 2; e_t = TIMEOUT - 1; e_cyc = TIMEOUT - 1;
    e_fa = m_ta[e_match]; e_fd = m_td[e_match];
  endtask

  // Arm, play the schedule until done (bounded), spray junk writes to check
  // the result is frozen, then compare against the prediction.
  task automatic run(input int n, input bit we, input int widx,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    num_exp = NW'(n); start = 1'b1;
    if (we) begin tbl_we = 1'b1; tbl_idx = IW'(widx); tbl_addr = wa; tbl_data = wd; end
    tick();
    start = 1'b0; tbl_we = 1'b0;
    if (we) begin m_ta[widx] = wa; m_td[widx] = wd; end
    m_num = n;
    predict();
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    got_t = -1;
    for (int t = 0; t < TIMEOUT + 2 && got_t < 0; t++) begin
      bus.memwrite = sch_en[t]; bus.dataadr = sch_a[t]; bus.writedata = sch_d[t];
      tick();
      bus.memwrite = 1'b0;
      if (done) got_t = t;
    end
    for (int k = 0; k < 3; k++) begin
      bus.memwrite = 1'b1; bus.dataadr = $urandom; bus.writedata = $urandom;
      tick();
    end
    bus.memwrite = 1'b0;
    chk("decide_cycle", 64'(got_t), 64'(e_t));
    chk("pass", {63'd0, pass}, {63'd0, e_pass});
    chk("fail", {63'd0, fail}, {63'd0, !e_pass});
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("fail_code", 64'(fail_code), 64'(e_code));
    chk("match_cnt", 64'(match_cnt), 64'(e_match));
    chk("ign_cnt", 64'(ign_cnt), 64'(e_ign));
    chk("cycles", 64'(cycles), 64'(e_cyc));
`ifdef MWCHK_CAPTURE_EN
    chk("fail_addr", 64'(fail_addr), 64'(e_fa));
    chk("fail_data", 64'(fail_data), 64'(e_fd));
`else
    chk("fail_addr", 64'(fail_addr), 64'd0);
    chk("fail_data", 64'(fail_data), 64'd0);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {60'd0, busy, done, pass, fail}, 64'd0);
    chk({tag, "_code"}, 64'(fail_code), 64'd0);
    chk({tag, "_cnts"}, {28'd0, match_cnt, ign_cnt, cycles}, 64'd0);
    chk({tag, "_cap"}, {fail_addr, fail_data}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_ta[i] = '0; m_td[i] = '0; end
  endtask

  initial begin
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
    do_reset();
    chk_zero("reset");

    // baseline: two ignored writes then the expected one
    wr_tbl(0, 32'h84, 32'h7);
    ign_base = 32'h80; ign_mask = 32'hFFFF_FFFF;
    clear_sch(); put(0, 32'h80, 32'h11); put(1, 32'h80, 32'h22); put(2, 32'h84, 32'h7);
    run(1, 0, 0, '0, '0);
    chk("base_pass", {62'd0, pass, fail}, 64'd2);
    chk("base_ign", 64'(ign_cnt), 64'd2);

    // unexpected write
    clear_sch(); put(0, 32'h88, 32'h5);
    run(1, 0, 0, '0, '0);
    chk("unexp_code", 64'(fail_code), 64'd1);

    // ordering
    wr_tbl(1, 32'h88, 32'h9);
    ign_base = 32'h0;
    clear_sch(); put(0, 32'h88, 32'h9);
    run(2, 0, 0, '0, '0);
    chk("order_code", 64'(fail_code), 64'd1);
    clear_sch(); put(0, 32'h84, 32'h7); put(3, 32'h88, 32'h9);
    run(2, 0, 0, '0, '0);
    chk("order_match", 64'(match_cnt), 64'd2);

    // timeout: no writes
    clear_sch();
    run(2, 0, 0, '0, '0);
    chk("tmo_code", 64'(fail_code), 64'd2);
    chk("tmo_cycles", 64'(cycles), 64'(TIMEOUT - 1));

    // final match on the timeout cycle, unexpected write on the timeout cycle
    clear_sch(); put(TIMEOUT - 1, 32'h84, 32'h7);
    run(1, 0, 0, '0, '0);
    chk("tmo_match_pass", {63'd0, pass}, 64'd1);
    clear_sch(); put(TIMEOUT - 1, 32'h99, 32'h1);
    run(1, 0, 0, '0, '0);
    chk("tmo_unexp_code", 64'(fail_code), 64'd1);

    // table write together with start is used by that run
    clear_sch(); put(0, 32'h44, 32'h3);
    run(1, 1, 0, 32'h44, 32'h3);
    chk("we_start_pass", {63'd0, pass}, 64'd1);

    // randomized runs
    for (int it = 0; it < 24; it++) begin
      int n, gp;
      n = $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++)
        wr_tbl(i, 32'h1000_0000 | ($urandom & 32'hFFFF), $urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: ign_mask = 32'hFFFF_FF00;
        1: ign_mask = 32'hFFFF_FFF0;
        default: ign_mask = 32'hFFFF_FFFF;
      endcase
      ign_base = 32'h2000_0000 | ($urandom & 32'h00FF_FFFF);
      clear_sch(); gp = 0;
      for (int t = 0; t < TIMEOUT - 1; t++) begin
        int r;
        r = $urandom_range(0, 31);
        if (r >= 10 && r < 20 && gp < n) begin put(t, m_ta[gp], m_td[gp]); gp++; end
        else if (r >= 20 && r < 28) put(t, (ign_base & ign_mask) | ($urandom & ~ign_mask), $urandom);
        else if (r == 30 && gp < n) put(t, m_ta[gp], m_td[gp] ^ 32'h100);
        else if (r == 31) put(t, 32'h3000_0000 | ($urandom & 32'hFFFF), $urandom);
      end
      run(n, 0, 0, '0, '0);
    end

    // reset mid-RUN after one match
    ign_base = 32'h2000_0000; ign_mask = 32'hFFFF_FFFF;
    wr_tbl(0, 32'h84, 32'h7); wr_tbl(1, 32'h88, 32'h9);
    num_exp = NW'(2); start = 1'b1; tick(); start = 1'b0;
    bus.memwrite = 1'b1; bus.dataadr = 32'h84; bus.writedata = 32'h7; tick();
    bus.memwrite = 1'b0;
    chk("mid_match", 64'(match_cnt), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_ta[i] = '0; m_td[i] = '0; end
    chk_zero("midreset");
    // cleared table: (0,0) is now the expected write
    clear_sch(); put(0, 32'h0, 32'h0);
    run(1, 0, 0, '0, '0);
    chk("cleared_tbl_pass", {63'd0, pass}, 64'd1);

    // empty table passes right after RUN is entered
    clear_sch();
    run(0, 0, 0, '0, '0);
    chk("empty_pass", {63'd0, pass}, 64'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
